// File: rtl/valid_ready_pipe.sv
// valid_ready_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse,
// combinational backpressure and synchronous flush.
module valid_ready_pipe #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 3,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    occupancy
);
   logic [DEPTH-1:0] v, adv, vs;
   logic [WIDTH-1:0] d  [DEPTH];
   logic [WIDTH-1:0] ds [DEPTH];
   logic             in_xfer, out_xfer;
   // a stage may advance when any stage from it to the output is empty, or the head drains
   for (genvar i = 0; i < DEPTH; i++) begin : g_adv
      assign adv[i] = out_ready || !(&v[DEPTH-1:i]);
   end
   always_comb begin
      vs[0] = in_valid && !flush;
      ds[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         vs[i] = v[i-1];
         ds[i] = d[i-1];
      end
   end
   assign in_ready  = adv[0] && !flush;
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   // data registers only capture real beats so bubbles leave held payloads intact
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v         <= '0;
         occupancy <= '0;
         for (int i = 0; i < DEPTH; i++) d[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            v[i] <= flush ? 1'b0 : adv[i] ? vs[i] : v[i];
            if (adv[i] && vs[i] && !flush) d[i] <= ds[i];
         end
         occupancy <= flush ? '0 : occupancy + CW'(in_xfer) - CW'(out_xfer);
      end
   end
endmodule

// File: tb/tb_valid_ready_pipe.sv
// tb_valid_ready_pipe: vector table, directed corner sequences and a randomized
// beat-position reference model for valid_ready_pipe (WIDTH=16, DEPTH=3).
module tb_valid_ready_pipe;
   localparam int W = 16;
   localparam int D = 3;
   localparam int CW = 2;

   logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  in_data, out_data;
   logic [CW-1:0] occupancy;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic         iv;
      logic [W-1:0] id;
      logic         ordy;
      logic         fl;
      logic         ov;
      logic [W-1:0] od;
      logic         ir;
      logic [1:0]   occ;
   } vec_t;
   vec_t tbl [22];

   typedef struct {
      logic [W-1:0] data;
      int           pos;
   } beat_t;
   beat_t        q[$];
   logic [W-1:0] last_out;
   int           lim;
   logic         r_iv, r_or, r_fl, e_ir, e_ov;
   logic [W-1:0] r_id;

   valid_ready_pipe #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // occupancy must always match the number of valid stages
   always @(negedge clk) begin
      if (!rst) begin
         n_vec++;
         if (int'(occupancy) != $countones(dut.v)) begin
            n_bad++;
            $display("FAIL occ_popcount: occupancy=%0d valid stages=%0d", occupancy, $countones(dut.v));
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk4(input string nm, input logic ov, input logic [W-1:0] od,
                       input logic ir, input int occ);
      chk({nm, "_out_valid"}, 32'(out_valid), 32'(ov));
      chk({nm, "_out_data"}, 32'(out_data), 32'(od));
      chk({nm, "_in_ready"}, 32'(in_ready), 32'(ir));
      chk({nm, "_occupancy"}, 32'(occupancy), 32'(occ));
   endtask

   task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   initial begin
      // latency
      tbl[0]  = '{1'b1, 16'hA5A5, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0};
      tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1};
      tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd1};
      tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hA5A5, 1'b1, 2'd1};
      tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hA5A5, 1'b1, 2'd0};
      // backpressure with a bubble, then release
      tbl[5]  = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 16'hA5A5, 1'b1, 2'd0};
      tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hA5A5, 1'b1, 2'd1};
      tbl[7]  = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 16'hA5A5, 1'b1, 2'd1};
      tbl[8]  = '{1'b1, 16'h0033, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b1, 2'd2};
      tbl[9]  = '{1'b1, 16'h0044, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 2'd3};
      tbl[10] = '{1'b1, 16'h0044, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 2'd3};
      tbl[11] = '{1'b1, 16'h0044, 1'b1, 1'b0, 1'b1, 16'h0011, 1'b1, 2'd3};
      tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0022, 1'b1, 2'd3};
      tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0033, 1'b1, 2'd2};
      tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0044, 1'b1, 2'd1};
      tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0044, 1'b1, 2'd0};
      // flush with two beats held, 0x00FF offered during flush
      tbl[16] = '{1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 16'h0044, 1'b1, 2'd0};
      tbl[17] = '{1'b1, 16'h0066, 1'b0, 1'b0, 1'b0, 16'h0044, 1'b1, 2'd1};
      tbl[18] = '{1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0, 16'h0044, 1'b0, 2'd2};
      tbl[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0044, 1'b1, 2'd0};
      tbl[20] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0044, 1'b1, 2'd0};
      tbl[21] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0044, 1'b1, 2'd0};

      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      chk4("reset", 1'b0, 16'h0000, 1'b1, 0);
      step();
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
         chk4($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].od, tbl[i].ir, int'(tbl[i].occ));
         step();
      end

      // streaming: 8 back-to-back beats
      for (int c = 0; c < 12; c++) begin
         int ins, outs;
         ins  = c < 8 ? c : 8;
         outs = c < 3 ? 0 : (c - 3 < 8 ? c - 3 : 8);
         drive(c < 8, c < 8 ? 16'(c + 1) : 16'h0000, 1'b1, 1'b0);
         chk4($sformatf("stream%0d", c), c >= 3 && c <= 10,
              c < 3 ? 16'h0044 : (c <= 10 ? 16'(c - 2) : 16'h0008), 1'b1, ins - outs);
         step();
      end

      // asynchronous reset while full and streaming
      for (int c = 0; c < 6; c++) begin
         drive(1'b1, 16'(16'h0100 + c), 1'b1, 1'b0);
         step();
      end
      drive(1'b1, 16'h0106, 1'b1, 1'b0);
      chk4("prerst", 1'b1, 16'h0103, 1'b1, 3);
      rst = 1'b1;
      #1;
      chk4("midrst", 1'b0, 16'h0000, 1'b1, 0);
      drive(1'b0, '0, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         drive(c == 0, c == 0 ? 16'h1234 : 16'h0000, 1'b1, 1'b0);
         chk4($sformatf("postrst%0d", c), c == 3, c >= 3 ? 16'h1234 : 16'h0000, 1'b1,
              (c >= 1 && c <= 3) ? 1 : 0);
         step();
      end

      // randomized traffic against a beat-position model
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      q.delete();
      last_out = '0;
      for (int n = 0; n < 1500; n++) begin
         r_iv = $urandom_range(0, 99) < 70;
         r_id = 16'($urandom);
         r_or = $urandom_range(0, 99) < 60;
         r_fl = $urandom_range(0, 99) < 4;
         e_ir = !r_fl && (q.size() < D || r_or);
         e_ov = q.size() > 0 && q[0].pos == D - 1;
         drive(r_iv, r_id, r_or, r_fl);
         chk4("rnd", e_ov, last_out, e_ir, q.size());
         if (r_fl) q.delete();
         else begin
            lim = r_or ? D : D - 1;
            foreach (q[k]) begin
               q[k].pos = (q[k].pos + 1 < lim) ? q[k].pos + 1 : lim;
               lim = q[k].pos - 1;
               if (q[k].pos == D - 1) last_out = q[k].data;
            end
            if (q.size() > 0 && q[0].pos == D) void'(q.pop_front());
            if (r_iv && e_ir) q.push_back('{r_id, 0});
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/valid_ready_pipe.md
Name: valid_ready_pipe

Overview:
- Parametrised multi-stage register pipeline with valid/ready flow control; successor to the plain and enabled D flip-flop registers.
- Carries a WIDTH-bit payload through DEPTH register stages and applies backpressure.
- Bubbles collapse, so a stalled output packs the pipeline.
- Synchronous flush for pipeline-kill events.
- Used between datapath blocks wherever registered retiming with handshake is needed.

Parameters:
- WIDTH, 16, payload width in bits (>=1).
- DEPTH, 3, number of register stages (>=1); unloaded latency in cycles.
- CW, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  pipe can accept a beat this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage DEPTH-1 holds a beat.
- out_ready  in  1  downstream accepts the beat this cycle.
- out_data  out  WIDTH  payload of stage DEPTH-1.
- occupancy  out  CW  number of valid stages, 0..DEPTH.

Behaviour:
- State: per stage i (0..DEPTH-1), a valid bit v[i] and a data register d[i]. Stage 0 is the input side; stage DEPTH-1 drives out_valid and out_data.
- Reset (asynchronous): all v=0, all d=0, occupancy=0. Therefore out_valid=0, out_data=0 and in_ready=1 (when flush=0). Reset wins over every other input, including mid-transfer; beats in flight are lost.
- Advance rule (combinational):
  - adv[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - adv[i] = !v[i] || adv[i+1], for i < DEPTH-1.
  - A stage loads whenever adv[i]=1.
- Stage loads:
  - d[i] <= d[i-1], v[i] <= v[i-1].
  - Stage 0: d[0] <= in_data, v[0] <= in_valid && !flush.
- A stage with adv[i]=0 holds its value. out_data must stay stable while out_valid=1 and out_ready=0.
- Data registers load only when the incoming valid is 1. Bubbles do not disturb held data, which is a power and debug aid.
- in_ready = adv[0] && !flush. The ready path is combinational from out_ready; no registered skid is required.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Latency: a beat accepted in cycle n appears with out_valid=1 in cycle n+DEPTH when no stall occurs.
- Throughput is 1 beat per cycle with out_ready held high.
- Bubble collapse: an empty stage always loads, so beats behind a stalled head advance until contiguous behind it. Full means all DEPTH stages are valid; in_ready=0 only when full and out_ready=0 (or flush=1).
- Ordering: strict FIFO; no beat is duplicated or dropped except by flush or reset.
- Flush:
  - When flush=1 at a rising edge, all v <= 0 and occupancy <= 0; d registers are unchanged.
  - in_ready=0 during flush, so no input transfer occurs.
  - out_valid may still be 1 in the flush cycle. If out_ready=1 in that cycle, the output transfer counts; the bench treats it as a completed beat.
- Simultaneous input and output transfer when full: both occur; occupancy is unchanged.
- occupancy is registered and updated each edge:
  - +1 on an input transfer only.
  - -1 on an output transfer only.
  - Unchanged when both or neither occur.
  - Forced to 0 by flush.
  - Must always equal popcount(v); this is an assertion in the bench.
- in_data and in_valid are ignored while in_ready=0.

Test Plan:
- Reset: assert rst mid-cycle with DEPTH=3 -> immediately out_valid=0, out_data=0x0000, occupancy=0, in_ready=1.
- Latency: single beat 0xA5A5 accepted in cycle 0 with out_ready=1 -> out_valid=1, out_data=0xA5A5 in cycle 3 only; occupancy returns to 0 in cycle 4.
- Streaming: 8 back-to-back beats 0x0001..0x0008 with out_ready=1 -> outputs 0x0001..0x0008 on consecutive cycles 3..10; in_ready stays 1 throughout.
- Backpressure and collapse: beats 0x0011, bubble, 0x0022, 0x0033, 0x0044 offered with out_ready=0 -> three beats accepted, occupancy=3, in_ready=0, out_data=0x0011 held.
  - Then out_ready=1 -> 0x0011, 0x0022, 0x0033, 0x0044 delivered in order, with no gaps after the stall releases.
- Flush: occupancy=2 with out_ready=0, pulse flush for 1 cycle while in_valid=1 with 0x00FF -> next cycle occupancy=0, out_valid=0, and 0x00FF is never output.
- Reset mid-stream: rst asserted while full and streaming -> all state cleared asynchronously; after release, a new beat 0x1234 emerges at latency DEPTH with no stale data.
